nerv_dbg_ctrl: RTL and testbench

- Hardware run-control unit between the GDB server stub and a NERV-class core; parametrised successor to the fixed single-core stub hookup.
- Provides halt, resume, N-instruction step, BNUM PC breakpoints and WNUM data watchpoints.
- Stalls the core's issue stage and reports stop events to the stub through a valid/ready channel.

---
 rtl/nerv_dbg_pkg.sv | 30 +++
 rtl/nerv_dbg_cmp.sv | 29 ++
 rtl/nerv_dbg_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_nerv_dbg_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nerv_dbg_pkg.sv
// Shared types for the NERV debug run-control unit: command/event encodings,
// FSM states and the breakpoint/watchpoint comparator entry.
package nerv_dbg_pkg;

    typedef enum logic [2:0] {
        OP_NOP, OP_HALT, OP_RESUME, OP_STEP,
        OP_BP_SET, OP_BP_CLR, OP_WP_SET, OP_WP_CLR
    } cmd_op_t;

    typedef enum logic [2:0] {
        RSN_RESET, RSN_HALT, RSN_STEP, RSN_BP, RSN_WP
    } evt_rsn_t;

    typedef enum logic [1:0] {
        ST_RUN, ST_STEP, ST_HALTED
    } dbg_state_t;

    localparam logic [1:0] WP_MODE_RD = 2'b01;
    localparam logic [1:0] WP_MODE_WR = 2'b10;

    // Entries hold a fixed-width address so one struct serves any XLEN up to 64.
    localparam int unsigned ADR_MAX = 64;

    typedef struct packed {
        logic               en;
        logic [ADR_MAX-1:0] adr;
        logic [1:0]         mode;
    } cmp_ent_t;

endpackage

// File: rtl/nerv_dbg_cmp.sv
// Address comparator bank: flags a hit on any enabled entry whose address and
// access mode match, and reports the lowest matching index.
module nerv_dbg_cmp
    import nerv_dbg_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned XLEN = 32
) (
    input  cmp_ent_t [N-1:0]  ent_i,
    input  logic [XLEN-1:0]   adr_i,
    input  logic [1:0]        mode_i,
    output logic              hit_o,
    output logic [3:0]        idx_o
);

    // Scan downwards so the lowest matching entry is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (ent_i[i-1].en && (ent_i[i-1].adr == ADR_MAX'(adr_i)) &&
                ((ent_i[i-1].mode & mode_i) != 2'b00)) begin
                hit_o = 1'b1;
                idx_o = 4'(i - 1);
            end
        end
    end

endmodule

// File: rtl/nerv_dbg_ctrl.sv
// Run-control unit between the GDB stub and a NERV-class core: halt, resume,
// N-step, PC breakpoints and data watchpoints with a single-entry event channel.
module nerv_dbg_ctrl
    import nerv_dbg_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned BNUM       = 4,
    parameter int unsigned WNUM       = 2,
    parameter int unsigned CW         = 16,
    parameter logic        RESET_HALT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  logic [2:0]      cmd_op,
    input  logic [3:0]      cmd_idx,
    input  logic [XLEN-1:0] cmd_adr,
    input  logic [CW-1:0]   cmd_arg,
    input  logic [XLEN-1:0] cpu_pc,
    input  logic            cpu_iss,
    input  logic            cpu_mvld,
    input  logic [XLEN-1:0] cpu_madr,
    input  logic            cpu_mwr,
    output logic            cpu_stall,
    output logic            halted,
    output logic            evt_vld,
    input  logic            evt_rdy,
    output logic [2:0]      evt_rsn,
    output logic [3:0]      evt_idx,
    output logic [XLEN-1:0] evt_pc
);

    dbg_state_t          state_q, state_d;
    logic                skip_q, skip_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    cmp_ent_t [BNUM-1:0] bp_q, bp_d;
    cmp_ent_t [WNUM-1:0] wp_q, wp_d;
    logic                evt_vld_q, evt_vld_d;
    evt_rsn_t            evt_rsn_q, evt_rsn_d;
    logic [3:0]          evt_idx_q, evt_idx_d;
    logic [XLEN-1:0]     evt_pc_q, evt_pc_d;

    cmd_op_t    op;
    logic       cmd_fire, issue;
    logic       bp_hit, wp_hit, bp_stop;
    logic [3:0] bp_idx, wp_idx;
    logic [1:0] wp_mode;
    logic       stop;
    evt_rsn_t   stop_rsn;
    logic [3:0] stop_idx;

    assign op       = cmd_op_t'(cmd_op);
    assign wp_mode  = !cpu_mvld ? 2'b00 : (cpu_mwr ? WP_MODE_WR : WP_MODE_RD);

    nerv_dbg_cmp #(.N(BNUM), .XLEN(XLEN)) u_bp_cmp (
        .ent_i  (bp_q),
        .adr_i  (cpu_pc),
        .mode_i ({2{cpu_iss}}),
        .hit_o  (bp_hit),
        .idx_o  (bp_idx)
    );

    nerv_dbg_cmp #(.N(WNUM), .XLEN(XLEN)) u_wp_cmp (
        .ent_i  (wp_q),
        .adr_i  (cpu_madr),
        .mode_i (wp_mode),
        .hit_o  (wp_hit),
        .idx_o  (wp_idx)
    );

    assign bp_stop   = bp_hit & ~skip_q;
    assign cpu_stall = (state_q == ST_HALTED) | bp_stop;
    assign halted    = (state_q == ST_HALTED);
    assign issue     = cpu_iss & ~cpu_stall;
    // RESUME/STEP wait for the pending event to be taken so it is never overwritten.
    assign cmd_rdy   = ~(evt_vld_q & ((op == OP_RESUME) | (op == OP_STEP)));
    assign cmd_fire  = cmd_vld & cmd_rdy;

    assign evt_vld = evt_vld_q;
    assign evt_rsn = evt_rsn_q;
    assign evt_idx = evt_idx_q;
    assign evt_pc  = evt_pc_q;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        cnt_d     = cnt_q;
        bp_d      = bp_q;
        wp_d      = wp_q;
        evt_vld_d = evt_vld_q;
        evt_rsn_d = evt_rsn_q;
        evt_idx_d = evt_idx_q;
        evt_pc_d  = evt_pc_q;
        stop      = 1'b0;
        stop_rsn  = RSN_HALT;
        stop_idx  = '0;

        if (issue) skip_d = 1'b0;
        if (evt_vld_q && evt_rdy) evt_vld_d = 1'b0;

        if (cmd_fire) begin
            for (int unsigned i = 0; i < BNUM; i++) begin
                if (cmd_idx == 4'(i)) begin
                    if (op == OP_BP_SET) begin
                        bp_d[i].en   = 1'b1;
                        bp_d[i].adr  = ADR_MAX'(cmd_adr);
                        bp_d[i].mode = 2'b11;
                    end else if (op == OP_BP_CLR) begin
                        bp_d[i].en   = 1'b0;
                    end
                end
            end
            for (int unsigned i = 0; i < WNUM; i++) begin
                if (cmd_idx == 4'(i)) begin
                    if (op == OP_WP_SET) begin
                        wp_d[i].en   = 1'b1;
                        wp_d[i].adr  = ADR_MAX'(cmd_adr);
                        wp_d[i].mode = cmd_arg[1:0];
                    end else if (op == OP_WP_CLR) begin
                        wp_d[i].en   = 1'b0;
                    end
                end
            end
        end

        case (state_q)
            ST_HALTED: begin
                if (cmd_fire && op == OP_RESUME) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else if (cmd_fire && op == OP_STEP) begin
                    state_d = ST_STEP;
                    skip_d  = 1'b1;
                    cnt_d   = (cmd_arg == '0) ? CW'(1) : cmd_arg;
                end
            end
            default: begin
                if (wp_hit) begin
                    stop = 1'b1; stop_rsn = RSN_WP; stop_idx = wp_idx;
                end else if (bp_stop) begin
                    stop = 1'b1; stop_rsn = RSN_BP; stop_idx = bp_idx;
                end else if (state_q == ST_STEP && issue && cnt_q <= CW'(1)) begin
                    stop = 1'b1; stop_rsn = RSN_STEP;
                end else if (cmd_fire && op == OP_HALT) begin
                    stop = 1'b1; stop_rsn = RSN_HALT;
                end

                if (stop) begin
                    state_d   = ST_HALTED;
                    evt_vld_d = 1'b1;
                    evt_rsn_d = stop_rsn;
                    evt_idx_d = stop_idx;
                    evt_pc_d  = cpu_pc;
                end else if (state_q == ST_STEP && issue) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_HALT ? ST_HALTED : ST_RUN;
            skip_q    <= 1'b0;
            cnt_q     <= '0;
            bp_q      <= '0;
            wp_q      <= '0;
            evt_vld_q <= RESET_HALT;
            evt_rsn_q <= RSN_RESET;
            evt_idx_q <= '0;
            evt_pc_q  <= '0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            cnt_q     <= cnt_d;
            bp_q      <= bp_d;
            wp_q      <= wp_d;
            evt_vld_q <= evt_vld_d;
            evt_rsn_q <= evt_rsn_d;
            evt_idx_q <= evt_idx_d;
            evt_pc_q  <= evt_pc_d;
        end
    end

endmodule

// File: tb/tb_nerv_dbg_ctrl.sv
// Directed bench for nerv_dbg_ctrl with a minimal in-order core model that
// advances its PC by 4 on every unstalled issue.
module tb_nerv_dbg_ctrl;
    import nerv_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [2:0]  cmd_op = OP_NOP;
    logic [3:0]  cmd_idx = '0;
    logic [31:0] cmd_adr = '0;
    logic [15:0] cmd_arg = '0;
    logic [31:0] cpu_pc;
    logic        cpu_iss;
    logic        cpu_mvld = 1'b0;
    logic [31:0] cpu_madr = '0;
    logic        cpu_mwr = 1'b0;
    logic        cpu_stall;
    logic        halted;
    logic        evt_vld;
    logic        evt_rdy = 1'b0;
    logic [2:0]  evt_rsn;
    logic [3:0]  evt_idx;
    logic [31:0] evt_pc;

    logic        core_on = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_val = '0;
    logic [31:0] pc_q;
    logic        iss_s = 1'b0;
    int          n_iss = 0;
    int          n100 = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          base;

    nerv_dbg_ctrl #(.XLEN(32), .BNUM(4), .WNUM(2), .CW(16), .RESET_HALT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
        .cmd_adr(cmd_adr), .cmd_arg(cmd_arg),
        .cpu_pc(cpu_pc), .cpu_iss(cpu_iss), .cpu_mvld(cpu_mvld), .cpu_madr(cpu_madr),
        .cpu_mwr(cpu_mwr), .cpu_stall(cpu_stall), .halted(halted),
        .evt_vld(evt_vld), .evt_rdy(evt_rdy), .evt_rsn(evt_rsn), .evt_idx(evt_idx),
        .evt_pc(evt_pc)
    );

    always #5 clk = ~clk;

    assign cpu_iss = core_on;
    assign cpu_pc  = pc_q;

    // Issue decision is taken mid-cycle so the PC update never races the DUT flops.
    always @(negedge clk) iss_s <= cpu_iss & ~cpu_stall;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else if (ld_en) begin
            pc_q <= ld_val;
        end else if (iss_s) begin
            pc_q  <= pc_q + 32'd4;
            n_iss <= n_iss + 1;
            if (pc_q == 32'h100) n100 <= n100 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] idx,
                        input logic [31:0] adr, input logic [15:0] arg);
        int n;
        cmd_op = op; cmd_idx = idx; cmd_adr = adr; cmd_arg = arg; cmd_vld = 1'b1;
        #1;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) chk("cmd_accept_timeout", {63'd0, cmd_rdy}, 64'd1);
        @(posedge clk); #2;
        cmd_vld = 1'b0;
    endtask

    task automatic ack();
        evt_rdy = 1'b1;
        cyc(1);
        evt_rdy = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        ld_val = v; ld_en = 1'b1;
        cyc(1);
        ld_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset into HALTED with a RESET event; RESUME must wait for the ack.
        cyc(2);
        rst = 1'b0;
        #1;
        chk("rst_halted", {63'd0, halted}, 64'd1);
        chk("rst_stall", {63'd0, cpu_stall}, 64'd1);
        chk("rst_evt_vld", {63'd0, evt_vld}, 64'd1);
        chk("rst_rsn", {61'd0, evt_rsn}, RSN_RESET);
        chk("rst_idx", {60'd0, evt_idx}, 64'd0);
        chk("rst_pc", {32'd0, evt_pc}, 64'd0);
        cmd_op = OP_RESUME; cmd_vld = 1'b1;
        #1;
        chk("resume_blocked", {63'd0, cmd_rdy}, 64'd0);
        cyc(2); #1;
        chk("resume_blocked_halted", {63'd0, halted}, 64'd1);
        evt_rdy = 1'b1;
        cyc(1);
        evt_rdy = 1'b0;
        #1;
        chk("ack_clears_evt", {63'd0, evt_vld}, 64'd0);
        chk("resume_ready", {63'd0, cmd_rdy}, 64'd1);
        cyc(1);
        cmd_vld = 1'b0;
        #1;
        chk("resume_unstall", {63'd0, cpu_stall}, 64'd0);

        // Breakpoint idx2 at 0x100: stall in the matching cycle, then step over it.
        send(OP_BP_SET, 4'd2, 32'h100, 16'd0);
        set_pc(32'hF8);
        core_on = 1'b1;
        cyc(2); #1;
        chk("bp_stall_same_cycle", {63'd0, cpu_stall}, 64'd1);
        chk("bp_pc_reached", {32'd0, cpu_pc}, 64'h100);
        chk("bp_not_yet_halted", {63'd0, halted}, 64'd0);
        cyc(1); #1;
        chk("bp_halted", {63'd0, halted}, 64'd1);
        chk("bp_evt_vld", {63'd0, evt_vld}, 64'd1);
        chk("bp_rsn", {61'd0, evt_rsn}, RSN_BP);
        chk("bp_idx", {60'd0, evt_idx}, 64'd2);
        chk("bp_evt_pc", {32'd0, evt_pc}, 64'h100);
        chk("bp_no_issue", 64'(n100), 64'd0);
        ack();
        send(OP_RESUME, 4'd0, 32'd0, 16'd0);
        #1;
        chk("bp_resume_no_rehit", {63'd0, cpu_stall}, 64'd0);
        cyc(3);
        core_on = 1'b0;
        #1;
        chk("bp_issued_once", 64'(n100), 64'd1);
        chk("bp_run_pc", {32'd0, cpu_pc}, 64'h10C);

        // HALT command, then STEP 3 and STEP 0 from 0x20.
        send(OP_HALT, 4'd0, 32'd0, 16'd0);
        #1;
        chk("halt_halted", {63'd0, halted}, 64'd1);
        chk("halt_rsn", {61'd0, evt_rsn}, RSN_HALT);
        ack();
        set_pc(32'h20);
        core_on = 1'b1;
        base = n_iss;
        send(OP_STEP, 4'd0, 32'd0, 16'd3);
        cyc(6); #1;
        chk("step3_issues", 64'(n_iss - base), 64'd3);
        chk("step3_pc", {32'd0, cpu_pc}, 64'h2C);
        chk("step3_halted", {63'd0, halted}, 64'd1);
        chk("step3_rsn", {61'd0, evt_rsn}, RSN_STEP);
        ack();
        base = n_iss;
        send(OP_STEP, 4'd0, 32'd0, 16'd0);
        cyc(4); #1;
        chk("step0_issues", 64'(n_iss - base), 64'd1);
        chk("step0_pc", {32'd0, cpu_pc}, 64'h30);
        chk("step0_rsn", {61'd0, evt_rsn}, RSN_STEP);
        core_on = 1'b0;
        ack();

        // Write watchpoint at 0x8000: reads pass, a write halts the next cycle.
        send(OP_WP_SET, 4'd0, 32'h8000, 16'd2);
        send(OP_RESUME, 4'd0, 32'd0, 16'd0);
        cpu_mvld = 1'b1; cpu_madr = 32'h8000; cpu_mwr = 1'b0;
        cyc(1);
        cpu_mvld = 1'b0;
        #1;
        chk("wp_read_no_stop", {63'd0, halted}, 64'd0);
        chk("wp_read_no_evt", {63'd0, evt_vld}, 64'd0);
        cpu_mvld = 1'b1; cpu_mwr = 1'b1;
        #1;
        chk("wp_write_no_stall_yet", {63'd0, cpu_stall}, 64'd0);
        cyc(1);
        cpu_mvld = 1'b0;
        #1;
        chk("wp_halted", {63'd0, halted}, 64'd1);
        chk("wp_rsn", {61'd0, evt_rsn}, RSN_WP);
        chk("wp_idx", {60'd0, evt_idx}, 64'd0);
        ack();

        // WP hit, BP match and HALT command in one cycle: one WP event.
        set_pc(32'hFC);
        send(OP_RESUME, 4'd0, 32'd0, 16'd0);
        core_on = 1'b1;
        cyc(1);
        cpu_mvld = 1'b1; cpu_madr = 32'h8000; cpu_mwr = 1'b1;
        cmd_op = OP_HALT; cmd_vld = 1'b1;
        #1;
        chk("prio_bp_stall", {63'd0, cpu_stall}, 64'd1);
        cyc(1);
        cpu_mvld = 1'b0; cmd_vld = 1'b0; core_on = 1'b0;
        #1;
        chk("prio_halted", {63'd0, halted}, 64'd1);
        chk("prio_rsn", {61'd0, evt_rsn}, RSN_WP);
        chk("prio_idx", {60'd0, evt_idx}, 64'd0);
        chk("prio_evt_pc", {32'd0, evt_pc}, 64'h100);
        cyc(1); #1;
        chk("prio_evt_stable_vld", {63'd0, evt_vld}, 64'd1);
        chk("prio_evt_stable_rsn", {61'd0, evt_rsn}, RSN_WP);

        // Asynchronous reset with the WP event still pending.
        rst = 1'b1;
        #1;
        chk("arst_rsn", {61'd0, evt_rsn}, RSN_RESET);
        chk("arst_evt_vld", {63'd0, evt_vld}, 64'd1);
        chk("arst_halted", {63'd0, halted}, 64'd1);
        cyc(1);
        rst = 1'b0;
        ack();
        set_pc(32'hF8);
        send(OP_RESUME, 4'd0, 32'd0, 16'd0);
        base = n100;
        core_on = 1'b1;
        cyc(6);
        core_on = 1'b0;
        #1;
        chk("arst_bp_cleared_run", {63'd0, halted}, 64'd0);
        chk("arst_bp_passed", 64'(n100 - base), 64'd1);
        chk("arst_pc_after", {32'd0, cpu_pc}, 64'h110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
